// File: rtl/attn_value_mac.sv
`timescale 1ns/1ps
// attn_value_mac: attention value-accumulation stage behind the softmax.
// It latches one Q0.15 probability vector and then takes N value rows. Each
// row is multiplied by that token's probability and added into D signed
// accumulators. The block then emits one saturated Q8.8 context vector.
// Build option: define ATTN_MAC_ROUND_EN for round-half-up output.
// Without it the output is truncated (floor).
module attn_value_mac #(
   parameter int N     = 8,
   parameter int D     = 4,
   parameter int P_W   = 16,
   parameter int V_W   = 16,
   parameter int ACC_W = 40,
   parameter int OUT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   input  logic [N-1:0][P_W-1:0]         p_vec,
   input  logic                          v_valid,
   input  logic [D-1:0][V_W-1:0]         v_row,
   output logic                          v_ready,
   output logic                          out_valid,
   output logic [D-1:0][OUT_W-1:0]       out_vec,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          drop_err
);

   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam int FRAC_SH = P_W - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef ATTN_MAC_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (FRAC_SH - 1);
`else
   localparam logic signed [ACC_W-1:0] RND_BIAS = '0;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [P_W-1:0]                p_q [N];
   logic [P_W-1:0]                p_d [N];
   logic signed [ACC_W-1:0]       acc_q [D];
   logic signed [ACC_W-1:0]       acc_d [D];
   logic [D-1:0][OUT_W-1:0]       out_q, out_d;
   logic                          drop_q, drop_d;
   logic signed [P_W+V_W:0]       prod [D];
   logic                          load_p;
   logic                          finish;

   // Q8.23 result scaled back to Q8.8 with optional rounding, then clamped.
   function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = (a + RND_BIAS) >>> FRAC_SH;
      if (s > SAT_MAX) begin
         return SAT_MAX[OUT_W-1:0];
      end else if (s < SAT_MIN) begin
         return SAT_MIN[OUT_W-1:0];
      end
      return s[OUT_W-1:0];
   endfunction

   // Unsigned probability of the current token times each signed value element.
   always_comb begin
      for (int d = 0; d < D; d++) begin
         prod[d] = $signed({1'b0, p_q[idx_q]}) * $signed(v_row[d]);
      end
   end

   // Next-state logic: load, accumulate, and result handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      p_d     = p_q;
      acc_d   = acc_q;
      out_d   = out_q;
      drop_d  = drop_q;
      load_p  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               load_p  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (valid_in) begin
               drop_d = 1'b1;
            end
            if (v_valid) begin
               for (int d = 0; d < D; d++) begin
                  acc_d[d] = acc_q[d] + ACC_W'(prod[d]);
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  finish  = 1'b1;
                  state_d = OUT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               if (valid_in) begin
                  load_p  = 1'b1;
                  state_d = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end else if (valid_in) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_p) begin
         for (int i = 0; i < N; i++) begin
            p_d[i] = p_vec[i];
         end
         for (int d = 0; d < D; d++) begin
            acc_d[d] = '0;
         end
         idx_d = '0;
      end
      if (finish) begin
         for (int d = 0; d < D; d++) begin
            out_d[d] = sat_out(acc_d[d]);
         end
      end
   end

   // State registers; reset aborts any in-flight vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         p_q     <= '{default: '0};
         acc_q   <= '{default: '0};
         out_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   assign v_ready   = (state_q == ACCUM);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign out_vec   = out_q;
   assign drop_err  = drop_q;

endmodule
